// File: rtl/wbs_addr_decoder.sv
// wbs_addr_decoder: Wishbone 1-to-N address decoder with timeout and registered responses
// Ports:
//   wb_clk_i, wb_rst_n_i          clock, asynchronous active-low reset
//   wbm_*_i / wbm_*_o             master side: request in; read data, ack, err, int out
//   wbs_*_o / wbs_*_i             slave side: one-hot cyc/stb, offset address, write data out;
//                                 packed per-slave read data, ack, err, int in
//   err_adr_o, err_cnt_o          last errored request address and saturating error count,
//                                 present only with WBS_ADDR_DECODER_ERR_CAPTURE_EN defined
module wbs_addr_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_HIGH = '0,
  parameter int TIMEOUT = 16
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_n_i,
  input  logic                             wbm_cyc_i,
  input  logic                             wbm_stb_i,
  input  logic                             wbm_we_i,
  input  logic [DATA_WIDTH/8-1:0]          wbm_sel_i,
  input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  output logic                             wbm_ack_o,
  output logic                             wbm_err_o,
  output logic                             wbm_int_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  output logic                             wbs_we_o,
  output logic [DATA_WIDTH/8-1:0]          wbs_sel_o,
  output logic [ADDR_WIDTH-1:0]            wbs_adr_o,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
`ifdef WBS_ADDR_DECODER_ERR_CAPTURE_EN
  output logic [ADDR_WIDTH-1:0]            err_adr_o,
  output logic [15:0]                      err_cnt_o,
`endif
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]            wbs_err_i,
  input  logic [NUM_SLAVES-1:0]            wbs_int_i
);
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, hit_idx;
  logic [ADDR_WIDTH-1:0] adr_q, offset;
  logic we_q, err_q, int_q, hit, req, sack, serr, tmo;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic [DATA_WIDTH-1:0] dat_q, rdat_q;
  logic [15:0] cnt_q;
  logic [NUM_SLAVES-1:0] oh;
  // descending scan so the lowest matching index is the last one written
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES-1; i >= 0; i--)
      if (wbm_adr_i >= SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] && wbm_adr_i <= SLAVE_HIGH[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
  assign offset = wbm_adr_i - SLAVE_BASE[int'(hit_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign req  = wbm_cyc_i & wbm_stb_i;
  assign sack = wbs_ack_i[idx_q];
  assign serr = wbs_err_i[idx_q];
  assign tmo  = cnt_q == 16'(TIMEOUT-1);
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) state_q <= IDLE;
    else state_q <= state_d;
  // a master abort takes priority over any slave response in the same cycle
  always_comb begin
    state_d = state_q == IDLE ? (req ? (hit ? WAIT : RESP) : IDLE) :
              state_q == WAIT ? (!wbm_cyc_i ? IDLE : (sack | serr | tmo) ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      idx_q  <= '0;
      adr_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      dat_q  <= '0;
      rdat_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      int_q <= |wbs_int_i;
      cnt_q <= state_q == WAIT ? cnt_q + 16'd1 : '0;
      if (state_q == IDLE && req) begin
        err_q <= ~hit;
        if (hit) begin
          idx_q <= hit_idx;
          adr_q <= offset;
          we_q  <= wbm_we_i;
          sel_q <= wbm_sel_i;
          dat_q <= wbm_dat_i;
        end
      end
      // ack together with err, or a timeout with no ack, both report an error
      if (state_q == WAIT) begin
        err_q <= serr | ~sack;
        if (sack && wbm_cyc_i) rdat_q <= wbs_dat_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`ifdef WBS_ADDR_DECODER_ERR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] req_adr_q, err_adr_q;
  logic [15:0] err_cnt_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      req_adr_q <= '0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && req) req_adr_q <= wbm_adr_i;
      if (state_q == RESP && err_q) begin
        err_adr_q <= req_adr_q;
        err_cnt_q <= err_cnt_q + {15'd0, ~&err_cnt_q};
      end
    end
  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;
`endif
  always_comb begin
    oh = '0;
    oh[idx_q] = state_q == WAIT;
    wbs_cyc_o = oh;
    wbs_stb_o = oh;
    wbm_ack_o = state_q == RESP && !err_q;
    wbm_err_o = state_q == RESP && err_q;
  end
  assign wbm_dat_o = rdat_q;
  assign wbm_int_o = int_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = sel_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = dat_q;
endmodule
